// File: rtl/regwb_pkg.sv
// regwb_pkg: shared sizing constants and the queue entry type for the
// register write-back queue (register_writeback and regwb_fifo).
package regwb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  // Pointer width indexes DEPTH slots; count needs one more bit to reach DEPTH.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } regwb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: in-order circular buffer of register write requests.
// Exposes the raw entry array, a per-slot valid mask, the head pointer and
// the occupancy so the parent can build the pending scoreboard and bypass.
// Flush outranks push/pop; reset outranks flush.
module regwb_fifo
  import regwb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  regwb_entry_t      push_entry,
  output regwb_entry_t      entries [DEPTH],
  output logic [DEPTH-1:0]  valid,
  output logic [PTR_W-1:0]  head,
  output logic [CNT_W-1:0]  count
);

  regwb_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: data only, no reset needed since validity comes from count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_entry;
  end

  // A slot is valid when its age relative to head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] age;
    age   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  assign entries = mem_q;
  assign head    = head_q;
  assign count   = count_q;

endmodule

// File: rtl/register_writeback.sv
// register_writeback: buffers write-back requests in an in-order queue and
// drains one per cycle into the register file write port when commit_en is
// high. Exports a pending-write scoreboard for decode stalls.
// Optional macro REGWB_BYPASS_EN builds the youngest-match lookup (lk_hit /
// lk_data); without it those outputs are tied to zero.
module register_writeback
  import regwb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 commit_en,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending,
  output logic [CNT_W-1:0]     count,
  input  logic [ADDR_W-1:0]    lk_addr,
  output logic                 lk_hit,
  output logic [DATA_W-1:0]    lk_data
);

  regwb_entry_t     entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] cnt;
  regwb_entry_t     push_entry;
  logic             push, pop;

  logic             rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  // Ready depends only on registered occupancy: no push while full, even if
  // a pop happens in the same cycle.
  assign wr_ready = (cnt < CNT_W'(DEPTH));

  // Writes to register 0 complete the handshake but are dropped.
  assign push       = wr_valid && wr_ready && (wr_addr != '0);
  assign pop        = commit_en && (cnt != '0);
  assign push_entry = '{addr: wr_addr, data: wr_data};

  regwb_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .entries    (entries),
    .valid      (valid),
    .head       (head),
    .count      (cnt)
  );

  // Commit register: strobe for one cycle per popped entry, hold index/data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (flush) begin
      rf_we_q    <= 1'b0;
    end else begin
      rf_we_q <= pop;
      if (pop) begin
        rf_waddr_q <= entries[head].addr;
        rf_wdata_q <= entries[head].data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = cnt;

  // Scoreboard: one-hot OR of every queued destination; register 0 never set.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending[entries[i].addr] = 1'b1;
    end
    pending[0] = 1'b0;
  end

`ifdef REGWB_BYPASS_EN
  // Lookup walks oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].addr == lk_addr) && (lk_addr != '0)) begin
        lk_hit  = 1'b1;
        lk_data = entries[idx].data;
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk = ^lk_addr;
  assign lk_hit    = 1'b0;
  assign lk_data   = '0;
`endif

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: reset, single write latency, full
// stall, x0/duplicates, flush, lookup and mid-traffic reset.
module tb_register_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_en;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [2:0]  count;
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit_en (commit_en),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pending   (pending),
    .count     (count),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},    64'(rf_we),    64'd1);
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'd1);
    chk({tag, ".rf_we"},    64'(rf_we),    64'd0);
    chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, ".count"},    64'(count),    64'd0);
    chk({tag, ".pending"},  64'(pending),  64'd0);
    chk({tag, ".lk_hit"},   64'(lk_hit),   64'd0);
    chk({tag, ".lk_data"},  64'(lk_data),  64'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_en = 1'b0; flush = 1'b0; lk_addr = '0;
    step();
    step();
    chk_reset_vals("init");
    rst_n = 1'b1;

    // Single write: push at edge N, strobe visible after edge N+1.
    commit_en = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_valid = 1'b0;
    chk("single.count_after_push", 64'(count),   64'd1);
    chk("single.pending5",         64'(pending), 64'h20);
    chk("single.no_early_we",      64'(rf_we),   64'd0);
    step();
    chk_commit("single.commit", 5'd5, 32'hDEADBEEF);
    chk("single.pending_clear",    64'(pending), 64'd0);
    chk("single.count_after_pop",  64'(count),   64'd0);
    step();
    chk("single.we_drop",          64'(rf_we),    64'd0);
    chk("single.waddr_hold",       64'(rf_waddr), 64'd5);

    // Full stall: four entries with commit disabled.
    commit_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      step();
    end
    chk("full.count",    64'(count),    64'd4);
    chk("full.ready",    64'(wr_ready), 64'd0);
    chk("full.pending",  64'(pending),  64'h1E);
    wr_addr = 5'd6; wr_data = 32'h600;
    step();
    chk("full.held_count", 64'(count), 64'd4);
    chk("full.held_no_we", 64'(rf_we), 64'd0);
    commit_en = 1'b1;
    step();
    chk_commit("full.c1", 5'd1, 32'h101);
    chk("full.no_push_when_full", 64'(count), 64'd3);
    chk("full.ready_again",       64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0;
    chk_commit("full.c2", 5'd2, 32'h102);
    chk("full.count_pushpop", 64'(count), 64'd3);
    step();
    chk_commit("full.c3", 5'd3, 32'h103);
    step();
    chk_commit("full.c4", 5'd4, 32'h104);
    step();
    chk_commit("full.c5", 5'd6, 32'h600);
    chk("full.drained", 64'(count), 64'd0);
    step();
    chk("full.idle_we", 64'(rf_we), 64'd0);

    // Register 0 dropped; duplicates committed in order.
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'd7;
    step();
    chk("x0.not_enqueued", 64'(count),   64'd0);
    chk("x0.pending0",     64'(pending), 64'd0);
    wr_addr = 5'd9; wr_data = 32'd1;
    step();
    chk("dup.count1",   64'(count),   64'd1);
    chk("dup.pending9", 64'(pending), 64'h200);
    chk("dup.no_we",    64'(rf_we),   64'd0);
    wr_addr = 5'd9; wr_data = 32'd2;
    step();
    wr_valid = 1'b0;
    chk_commit("dup.first", 5'd9, 32'd1);
    chk("dup.pending9_still", 64'(pending), 64'h200);
    step();
    chk_commit("dup.second", 5'd9, 32'd2);
    chk("dup.empty", 64'(count), 64'd0);
    step();

    // Flush with three queued entries and a concurrent push and pop.
    commit_en = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      step();
    end
    chk("flush.pre_count", 64'(count), 64'd3);
    chk("flush.pre_pending", 64'(pending), 64'h1C00);
    wr_addr = 5'd13; wr_data = 32'd13; flush = 1'b1; commit_en = 1'b1;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush.count",   64'(count),   64'd0);
    chk("flush.no_we",   64'(rf_we),   64'd0);
    chk("flush.pending", 64'(pending), 64'd0);
    step();
    chk("flush.no_we2",       64'(rf_we), 64'd0);
    chk("flush.no_late_push", 64'(count), 64'd0);

    // Lookup with draining stalled.
    commit_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h10;
    step();
    wr_addr = 5'd3; wr_data = 32'h20;
    step();
    wr_addr = 5'd7; wr_data = 32'h70;
    step();
    wr_valid = 1'b0;
    lk_addr = 5'd3; #1;
`ifdef REGWB_BYPASS_EN
    chk("lk.hit3",  64'(lk_hit),  64'd1);
    chk("lk.data3", 64'(lk_data), 64'h20);
`else
    chk("lk.hit3_off",  64'(lk_hit),  64'd0);
    chk("lk.data3_off", 64'(lk_data), 64'd0);
`endif
    lk_addr = 5'd7; #1;
`ifdef REGWB_BYPASS_EN
    chk("lk.hit7",  64'(lk_hit),  64'd1);
    chk("lk.data7", 64'(lk_data), 64'h70);
`else
    chk("lk.hit7_off", 64'(lk_hit), 64'd0);
`endif
    lk_addr = 5'd0; #1;
    chk("lk.miss0", 64'(lk_hit), 64'd0);
    lk_addr = 5'd8; #1;
    chk("lk.miss8", 64'(lk_hit), 64'd0);
    lk_addr = 5'd0;

    // Reset for two cycles with three entries queued and commit enabled.
    chk("rst.pre_count", 64'(count), 64'd3);
    rst_n = 1'b0; commit_en = 1'b1;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();
    chk("rst.no_we_after", 64'(rf_we), 64'd0);
    chk("rst.count_after", 64'(count), 64'd0);
    step();
    chk("rst.no_we_after2", 64'(rf_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
